insn_fetch_ctrl: RTL and testbench

//  Sequences instruction fetch and drives the instruction-valid qualifier.

---
 rtl/insn_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_insn_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch sequencer: requests a word from IMEM, holds it with a valid
// qualifier until decode consumes it, and handles stall, redirect and fetch timeout.
module insn_fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_imem_req,
    output logic [31:0]      o_insn,
    output logic             o_insn_vld,
    output logic             o_pc_en,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic             o_err
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_ERROR
    } state_t;

    state_t             state_q;
    logic               req_q;
    logic [31:0]        insn_q;
    logic               vld_q;
    logic [CNT_W-1:0]   retire_cnt_q;
    logic [CNT_W-1:0]   retire_cnt_d;
    logic               err_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_d;
    logic               drop_q;
    logic               pc_en;

    assign pc_en        = (state_q == S_VALID) && !i_stall && !i_flush;
    assign retire_cnt_d = retire_cnt_q + 1'b1;
    assign wait_cnt_d   = wait_cnt_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            insn_q       <= '0;
            vld_q        <= 1'b0;
            retire_cnt_q <= '0;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        wait_cnt_q <= '0;
                        // A stale response owed to an earlier redirect is swallowed, flush or not.
                        if (drop_q) begin
                            drop_q <= 1'b0;
                        end else if (!i_flush) begin
                            insn_q  <= i_imem_rdata;
                            vld_q   <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= S_VALID;
                        end
                    end else if (i_flush && !drop_q) begin
                        drop_q     <= 1'b1;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= S_ERROR;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                S_VALID: begin
                    if (i_flush || !i_stall) begin
                        state_q <= S_FETCH;
                        vld_q   <= 1'b0;
                        req_q   <= 1'b1;
                    end
                    if (pc_en) begin
                        retire_cnt_q <= retire_cnt_d;
                    end
                end
                default: begin
                    // Timeout is terminal until reset; all IMEM and redirect traffic is ignored.
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_imem_req   = req_q;
    assign o_insn       = insn_q;
    assign o_insn_vld   = vld_q;
    assign o_pc_en      = pc_en;
    assign o_retire_cnt = retire_cnt_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_insn_fetch_ctrl;

    localparam int T  = 4;
    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          ack   = 1'b0;
    logic [31:0]   rdata = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          o_imem_req;
    logic [31:0]   o_insn;
    logic          o_insn_vld;
    logic          o_pc_en;
    logic [CW-1:0] o_retire_cnt;
    logic          o_err;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    insn_fetch_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_imem_ack   (ack),
        .i_imem_rdata (rdata),
        .i_stall      (stall),
        .i_flush      (flush),
        .o_imem_req   (o_imem_req),
        .o_insn       (o_insn),
        .o_insn_vld   (o_insn_vld),
        .o_pc_en      (o_pc_en),
        .o_retire_cnt (o_retire_cnt),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: what the fetch unit is doing, not how it is encoded.
    bit          m_idle   = 1'b1;
    bit          m_have   = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_stale  = 1'b0;
    int          m_waited = 0;
    int          m_cnt    = 0;
    logic [31:0] m_word   = '0;

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_idle <= 1'b1; m_have <= 1'b0; m_err <= 1'b0; m_stale <= 1'b0;
            m_waited <= 0; m_cnt <= 0; m_word <= '0;
        end else if (m_err) begin
            m_err <= 1'b1;
        end else if (m_idle) begin
            m_idle <= 1'b0;
        end else if (m_have) begin
            if (flush) m_have <= 1'b0;
            else if (!stall) begin
                m_have <= 1'b0;
                m_cnt  <= (m_cnt + 1) % (1 << CW);
            end
        end else if (ack) begin
            m_waited <= 0;
            if (m_stale) m_stale <= 1'b0;
            else if (!flush) begin
                m_have <= 1'b1;
                m_word <= rdata;
            end
        end else if (flush && !m_stale) begin
            m_stale  <= 1'b1;
            m_waited <= 0;
        end else begin
            m_waited <= m_waited + 1;
            if (m_waited + 1 == T) m_err <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (run_cmp) begin
            chk("model_req",  o_imem_req,   !m_idle && !m_have && !m_err);
            chk("model_vld",  o_insn_vld,   m_have);
            chk("model_insn", o_insn,       m_word);
            chk("model_pcen", o_pc_en,      m_have && !stall && !flush);
            chk("model_cnt",  o_retire_cnt, m_cnt);
            chk("model_err",  o_err,        m_err);
        end
    end

    task automatic cyc(input bit a, input logic [31:0] d, input bit s, input bit f);
        @(posedge i_clk);
        #1;
        ack = a; rdata = d; stall = s; flush = f;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},  o_imem_req,   0);
        chk({tag, "_vld"},  o_insn_vld,   0);
        chk({tag, "_insn"}, o_insn,       0);
        chk({tag, "_pcen"}, o_pc_en,      0);
        chk({tag, "_cnt"},  o_retire_cnt, 0);
        chk({tag, "_err"},  o_err,        0);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        #1;
        chk_reset_outputs(tag);
        @(posedge i_clk);
        #1;
        ack = 1'b0; stall = 1'b0; flush = 1'b0; i_rst = 1'b1;
    endtask

    initial begin
        #2 i_rst = 1'b0;
        #1 chk_reset_outputs("rst0");
        run_cmp = 1'b1;
        cyc(0, 0, 0, 0);
        i_rst = 1'b1;

        // Zero-wait fetch
        cyc(1, 32'h00500093, 0, 0);
        chk("zw_req", o_imem_req, 1);
        cyc(0, 0, 0, 0);
        chk("zw_vld", o_insn_vld, 1);
        chk("zw_insn", o_insn, 32'h00500093);
        chk("zw_pcen", o_pc_en, 1);
        cyc(0, 0, 0, 0);
        chk("zw_cnt", o_retire_cnt, 1);
        chk("zw_vld_off", o_insn_vld, 0);
        chk("zw_req2", o_imem_req, 1);

        // Three wait states, then stall five cycles in VALID
        cyc(0, 0, 0, 0);
        chk("ws_req2", o_imem_req, 1);
        cyc(0, 0, 0, 0);
        chk("ws_req3", o_imem_req, 1);
        cyc(1, 32'hDEADBEEF, 0, 0);
        chk("ws_req4", o_imem_req, 1);
        chk("ws_vld_pre", o_insn_vld, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0);
            chk("st_vld", o_insn_vld, 1);
            chk("st_insn", o_insn, 32'hDEADBEEF);
            chk("st_pcen", o_pc_en, 0);
            chk("st_cnt", o_retire_cnt, 1);
        end
        cyc(0, 0, 0, 0);
        chk("st_pcen_rel", o_pc_en, 1);
        cyc(1, 32'h11111111, 0, 0);
        chk("st_cnt2", o_retire_cnt, 2);

        // Flush in VALID (with stall also high)
        cyc(0, 0, 1, 1);
        chk("fv_vld", o_insn_vld, 1);
        chk("fv_pcen", o_pc_en, 0);
        cyc(0, 0, 0, 1);
        chk("fv_vld_off", o_insn_vld, 0);
        chk("fv_req", o_imem_req, 1);
        chk("fv_cnt", o_retire_cnt, 2);

        // That flush in FETCH (no ack) arms a drop
        cyc(1, 32'hAAAAAAAA, 0, 0);
        chk("ff_req", o_imem_req, 1);
        cyc(1, 32'h12345678, 0, 0);
        chk("ff_dropped", o_insn_vld, 0);
        cyc(0, 0, 0, 0);
        chk("ff_vld", o_insn_vld, 1);
        chk("ff_insn", o_insn, 32'h12345678);

        // Timeout after T ack-less FETCH cycles
        for (int i = 0; i < T; i++) begin
            cyc(0, 0, 0, 0);
            chk("to_err_pre", o_err, 0);
        end
        cyc(1, 32'h55555555, 0, 1);
        chk("to_err", o_err, 1);
        chk("to_req", o_imem_req, 0);
        chk("to_vld", o_insn_vld, 0);
        cyc(1, 32'h66666666, 0, 0);
        cyc(0, 0, 0, 0);
        chk("to_sticky", o_err, 1);
        chk("to_insn", o_insn, 32'h12345678);
        async_reset("arst_err");

        // Counter wrap: 17 consumes on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            cyc(1, 32'(i), 0, 0);
            cyc(0, 0, 0, 0);
        end
        cyc(1, 32'hCAFEF00D, 0, 0);
        chk("wrap_cnt", o_retire_cnt, 1);
        cyc(0, 0, 1, 0);
        chk("mv_vld", o_insn_vld, 1);
        async_reset("arst_valid");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0 || (m_err && $urandom_range(0, 9) == 0)) begin
                async_reset("arst_rand");
            end else begin
                cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) == 0);
            end
        end

        @(negedge i_clk);
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
